// File: rtl/game_pkg.sv
// Shared game definitions: difficulty encodings, mole up-times, the mole
// FSM state type and the hole count.
package game_pkg;

  localparam int NUM_HOLES = 8;

  localparam logic [1:0] DIFF_EASY   = 2'b00;
  localparam logic [1:0] DIFF_NORMAL = 2'b01;
  localparam logic [1:0] DIFF_HARD   = 2'b10;
  localparam logic [1:0] DIFF_EXPERT = 2'b11;

  localparam logic [10:0] UP_MS_EASY   = 11'd1200;
  localparam logic [10:0] UP_MS_NORMAL = 11'd900;
  localparam logic [10:0] UP_MS_HARD   = 11'd600;
  localparam logic [10:0] UP_MS_EXPERT = 11'd400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } mole_state_t;

  // Mole up-time in ms for a difficulty code.
  function automatic logic [10:0] up_ms_for(input logic [1:0] diff);
    logic [10:0] ms;
    case (diff)
      DIFF_EASY:   ms = UP_MS_EASY;
      DIFF_NORMAL: ms = UP_MS_NORMAL;
      DIFF_HARD:   ms = UP_MS_HARD;
      default:     ms = UP_MS_EXPERT;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; free-running, reloads seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Shift left, feeding back the XOR of the tap bits.
  always_comb begin
    q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: IDLE/GAP/UP FSM with a ms timebase, random hole
// selection from an LFSR, and registered hit/miss pulses.
// Optional build macro MOLE_WRONG_PENALTY_EN: a press of only unlit holes
// while a mole is up counts as a miss and ends the mole.
module mole_spawner
  import game_pkg::*;
#(
  parameter int          MS_DIV    = 100000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_mole_ctrl,
  input  logic [1:0] difficulty_level,
  input  logic [7:0] btn_hole,
  output logic [7:0] mole_mask,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       mole_active
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  mole_state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [10:0]   ms_q, ms_d;
  logic [10:0]   up_lat_q, up_lat_d;
  logic          first_gap_q, first_gap_d;
  logic [2:0]    prev_hole_q, prev_hole_d;
  logic [7:0]    mask_q, mask_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          active_q, active_d;

  logic [15:0]   lfsr_q;
  logic          lfsr_unused;
  logic          ms_tick;
  logic [10:0]   gap_ms;
  logic          gap_done;
  logic          up_done;
  logic [2:0]    pick;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only the low three LFSR bits choose a hole.
  assign lfsr_unused = ^lfsr_q[15:3];

  // Timebase and timeout decode; "reached" means the ms counter is about to
  // step onto the target, so each phase lasts exactly target*MS_DIV cycles.
  always_comb begin
    ms_tick  = (presc_q == PW'(MS_DIV - 1));
    gap_ms   = (first_gap_q ? up_ms_for(difficulty_level) : up_lat_q) >> 1;
    gap_done = ms_tick && ((ms_q + 11'd1) == gap_ms);
    up_done  = ms_tick && ((ms_q + 11'd1) == up_lat_q);
    pick     = (lfsr_q[2:0] == prev_hole_q) ? (lfsr_q[2:0] + 3'd1) : lfsr_q[2:0];
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d     = state_q;
    presc_d     = ms_tick ? '0 : presc_q + 1'b1;
    ms_d        = ms_tick ? ms_q + 11'd1 : ms_q;
    up_lat_d    = up_lat_q;
    first_gap_d = first_gap_q;
    prev_hole_d = prev_hole_q;
    mask_d      = mask_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    if (!enable_mole_ctrl) begin
      // Disable wins over everything: drop the mole and any pending pulse.
      state_d = IDLE;
      mask_d  = 8'h00;
      presc_d = '0;
      ms_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = GAP;
          first_gap_d = 1'b1;
          mask_d      = 8'h00;
          presc_d     = '0;
          ms_d        = '0;
        end
        GAP: begin
          if (gap_done) begin
            state_d     = UP;
            up_lat_d    = up_ms_for(difficulty_level);
            first_gap_d = 1'b0;
            prev_hole_d = pick;
            mask_d      = 8'b1 << pick;
            presc_d     = '0;
            ms_d        = '0;
          end
        end
        UP: begin
          if ((btn_hole & mask_q) != 8'h00) begin
            // A lit-hole press beats a coincident timeout or wrong press.
            hit_d   = 1'b1;
            state_d = GAP;
            mask_d  = 8'h00;
            presc_d = '0;
            ms_d    = '0;
          end else if (up_done) begin
            miss_d  = 1'b1;
            state_d = GAP;
            mask_d  = 8'h00;
            presc_d = '0;
            ms_d    = '0;
          end
`ifdef MOLE_WRONG_PENALTY_EN
          else if (btn_hole != 8'h00) begin
            miss_d  = 1'b1;
            state_d = GAP;
            mask_d  = 8'h00;
            presc_d = '0;
            ms_d    = '0;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          mask_d  = 8'h00;
          presc_d = '0;
          ms_d    = '0;
        end
      endcase
    end

    active_d = (state_d == UP);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      ms_q        <= '0;
      up_lat_q    <= '0;
      first_gap_q <= 1'b0;
      prev_hole_q <= 3'd0;
      mask_q      <= 8'h00;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      up_lat_q    <= up_lat_d;
      first_gap_q <= first_gap_d;
      prev_hole_q <= prev_hole_d;
      mask_q      <= mask_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      active_q    <= active_d;
    end
  end

  assign mole_mask   = mask_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign mole_active = active_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: a cycle-level reference model predicts
// mole/hit/miss events into a queue; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_mole_spawner;

  localparam int          MS_DIV = 10;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] diff  = 2'b00;
  logic [7:0] btn   = 8'h00;
  logic [7:0] mole_mask;
  logic       hit_pulse, miss_pulse, mole_active;

  mole_spawner #(.MS_DIV(MS_DIV), .LFSR_SEED(SEED)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_mole_ctrl (en),
    .difficulty_level (diff),
    .btn_hole         (btn),
    .mole_mask        (mole_mask),
    .hit_pulse        (hit_pulse),
    .miss_pulse       (miss_pulse),
    .mole_active      (mole_active)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  localparam int EV_MOLE = 0, EV_HIT = 1, EV_MISS = 2;
  typedef struct { int kind; logic [7:0] mask; int cyc; } ev_t;
  ev_t evq[$];
  int  cyc = 0;

`ifdef MOLE_WRONG_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 idle, 1 gap, 2 up; m_el counts whole cycles spent in the state.
  int         m_state = 0;
  int         m_el    = 0;
  int         m_up_ms = 0;
  bit         m_first = 1'b0;
  int         m_prev  = 0;
  int         m_hole  = 0;
  logic [7:0] m_mask  = 8'h00;
  logic [15:0] m_lfsr = SEED;

  function automatic int up_ms(input logic [1:0] d);
    case (d)
      2'b00:   return 1200;
      2'b01:   return 900;
      2'b10:   return 600;
      default: return 400;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic void leave_up(input int kind);
    evq.push_back('{kind, 8'h00, cyc});
    m_state = 1;
    m_el    = 0;
    m_mask  = 8'h00;
  endfunction

  always @(posedge clk) begin : model
    int gap;
    int h;
    cyc++;
    if (!rst_n) begin
      m_state = 0; m_el = 0; m_up_ms = 0; m_first = 1'b0;
      m_prev  = 0; m_mask = 8'h00; m_lfsr = SEED;
    end else begin
      if (!en) begin
        m_state = 0; m_el = 0; m_mask = 8'h00;
      end else if (m_state == 0) begin
        m_state = 1; m_el = 0; m_first = 1'b1;
      end else if (m_state == 1) begin
        gap = (m_first ? up_ms(diff) : m_up_ms) / 2;
        if (m_el == gap * MS_DIV - 1) begin
          h = int'(m_lfsr[2:0]);
          if (h == m_prev) h = (h + 1) % 8;
          m_prev  = h;
          m_hole  = h;
          m_mask  = 8'(1 << h);
          m_up_ms = up_ms(diff);
          m_first = 1'b0;
          m_state = 2;
          m_el    = 0;
          evq.push_back('{EV_MOLE, m_mask, cyc});
        end else m_el++;
      end else begin
        if (btn[m_hole])                        leave_up(EV_HIT);
        else if (m_el == m_up_ms * MS_DIV - 1)  leave_up(EV_MISS);
        else if (PENALTY && btn != 8'h00)       leave_up(EV_MISS);
        else                                    m_el++;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] prev_mask = 8'h00;
  logic [7:0] last_mole = 8'h00;

  always @(negedge clk) begin : monitor
    int   kind;
    ev_t  e;
    chk("mask_track", mole_mask, m_mask);
    chk("active_track", mole_active, (m_state == 2));
    chk("hit_and_miss", hit_pulse & miss_pulse, 1'b0);
    if (hit_pulse || miss_pulse || (prev_mask == 8'h00 && mole_mask != 8'h00)) begin
      kind = hit_pulse ? EV_HIT : (miss_pulse ? EV_MISS : EV_MOLE);
      if (kind == EV_MOLE) begin
        chk("mask_onehot", $onehot(mole_mask), 1'b1);
        if (last_mole != 8'h00) chk("hole_repeat", (mole_mask == last_mole), 1'b0);
        last_mole = mole_mask;
      end
      if (evq.size() == 0) begin
        fail($sformatf("unexpected event kind %0d", kind));
      end else begin
        e = evq.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (kind == EV_MOLE) chk("event_mask", mole_mask, e.mask);
      end
    end
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      fail($sformatf("missing event kind %0d due at cycle %0d", e.kind, e.cyc));
    end
    prev_mask = mole_mask;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] wrong_of(input logic [7:0] m);
    logic [7:0] w;
    w = 8'(1 << $urandom_range(0, 7));
    if (w == m) w = {w[6:0], w[7]};
    return w;
  endfunction

  task automatic run(input int n, input int p_hit, input int p_wrong, input int p_idle);
    int r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn = 8'h00;
      r = $urandom_range(0, 999);
      if (m_state == 2) begin
        if (r < p_hit)
          btn = m_mask | (($urandom_range(0, 1) == 1) ? wrong_of(m_mask) : 8'h00);
        else if (r < p_hit + p_wrong)
          btn = wrong_of(m_mask);
      end else if (r < p_idle) begin
        btn = 8'(1 << $urandom_range(0, 7));
      end
    end
    @(negedge clk);
    btn = 8'h00;
  endtask

  task automatic wait_up(input int budget);
    int n = 0;
    while (m_state != 2 && n < budget) begin
      @(negedge clk);
      btn = 8'h00;
      n++;
    end
    if (m_state != 2) fail("wait_up timeout");
  endtask

  // Counts negedges until the selected DUT output is high (0: mole_active, 1: miss_pulse).
  task automatic count_until(input int sel, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      btn = 8'h00;
      n++;
    end while (!((sel == 0) ? mole_active : miss_pulse) && n < budget);
  endtask

  // ---------------- scenarios ----------------
  initial begin : stim
    int n;
    logic [7:0] held;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mask", mole_mask, 8'h00);
    chk("rst_hit", hit_pulse, 1'b0);
    chk("rst_miss", miss_pulse, 1'b0);
    chk("rst_active", mole_active, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 1: easy, first GAP is 600 ms (+1 IDLE cycle), then a hit
    diff = 2'b00;
    en   = 1'b1;
    count_until(0, 7000, n);
    chk("s1_gap_cycles", n, 6001);
    chk("s1_onehot", $onehot(mole_mask), 1'b1);
    chk("s1_active", mole_active, 1'b1);
    repeat (50) @(negedge clk);
    btn = m_mask;
    @(negedge clk);
    btn = 8'h00;
    chk("s1_hit", hit_pulse, 1'b1);
    chk("s1_hit_mask", mole_mask, 8'h00);
    chk("s1_hit_nomiss", miss_pulse, 1'b0);

    // Scenario 2: expert, no press -> 400 ms timeout, then 200 ms GAP
    en = 1'b0;
    repeat (3) @(negedge clk);
    diff = 2'b11;
    en   = 1'b1;
    count_until(0, 3000, n);
    chk("s2_first_gap", n, 2001);
    count_until(1, 5000, n);
    chk("s2_up_cycles", n, 4000);
    @(negedge clk);
    chk("s2_miss_width", miss_pulse, 1'b0);
    chk("s2_mask_after", mole_mask, 8'h00);
    count_until(0, 3000, n);
    chk("s2_gap_cycles", n, 1999);

    // Scenario 3: random hits and ignored presses during GAP
    run(10000, 6, 0, 20);

    // Scenario 4: lit+wrong press together, mid-UP and on the timeout cycle
    wait_up(5000);
    repeat ($urandom_range(5, 200)) @(negedge clk);
    btn = m_mask | wrong_of(m_mask);
    @(negedge clk);
    btn = 8'h00;
    chk("s4_hit", hit_pulse, 1'b1);
    chk("s4_nomiss", miss_pulse, 1'b0);
    wait_up(5000);
    n = 0;
    while (!(m_state == 2 && m_el == m_up_ms * MS_DIV - 1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    btn = m_mask | wrong_of(m_mask);
    @(negedge clk);
    btn = 8'h00;
    chk("s4_timeout_hit", hit_pulse, 1'b1);
    chk("s4_timeout_nomiss", miss_pulse, 1'b0);

    // Scenario 5: drop enable mid-UP, then re-enable restarts GAP from 0
    wait_up(5000);
    repeat (30) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("s5_mask", mole_mask, 8'h00);
    chk("s5_hit", hit_pulse, 1'b0);
    chk("s5_miss", miss_pulse, 1'b0);
    chk("s5_active", mole_active, 1'b0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    count_until(0, 3000, n);
    chk("s5_regap", n, 2001);

    // Scenario 6: wrong-hole press only
    repeat (20) @(negedge clk);
    held = m_mask;
    btn  = wrong_of(m_mask);
    @(negedge clk);
    btn = 8'h00;
`ifdef MOLE_WRONG_PENALTY_EN
    chk("s6_miss", miss_pulse, 1'b1);
    chk("s6_mask", mole_mask, 8'h00);
`else
    chk("s6_miss", miss_pulse, 1'b0);
    chk("s6_mask", mole_mask, held);
`endif
    chk("s6_hit", hit_pulse, 1'b0);

    // Asynchronous reset mid-UP clears the mole at once, with no pulse
    wait_up(5000);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mask", mole_mask, 8'h00);
    chk("arst_active", mole_active, 1'b0);
    chk("arst_hit", hit_pulse, 1'b0);
    chk("arst_miss", miss_pulse, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Mixed random traffic with wrong presses and a changed difficulty
    run(3000, 5, 4, 20);
    en = 1'b0;
    repeat (3) @(negedge clk);
    diff = 2'($urandom_range(2, 3));
    en   = 1'b1;
    run(6000, 5, 4, 20);

    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
